// File: rtl/dff_r_pkg.sv
// ----------------------------------------------------------------------------
// dff_r_pkg
//   Shared width and reset constants for the dff_r register family.
//
//   STATE_W     : FSM state register width (3 bits)
//   PTR_W       : FIFO head/tail pointer width, 16 entries (4 bits)
//   COUNT_W     : FIFO data count width, 0..16 (5 bits)
//   DFF_RST_VAL : default reset value loaded while reset_n is low
//
//   Optional feature macro: DFF_R_LOAD_EN (adds an 'en' load-enable input
//   to the core and to every wrapper).
// ----------------------------------------------------------------------------
package dff_r_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PTR_W   = 4;
    localparam int unsigned COUNT_W = 5;

    localparam int unsigned DFF_W_MIN = 1;
    localparam int unsigned DFF_W_MAX = 32;

    localparam logic [31:0] DFF_RST_VAL = 32'd0;

endpackage : dff_r_pkg

// File: rtl/dff_r_wrap.sv
// ----------------------------------------------------------------------------
// dff3_r / dff4_r / dff5_r
//   Fixed-width wrappers around dff_r kept under the names existing parent
//   modules instantiate. Reset value is the package default (0).
//
//     dff3_r : WIDTH = STATE_W (3), FSM state
//     dff4_r : WIDTH = PTR_W   (4), FIFO head/tail pointer
//     dff5_r : WIDTH = COUNT_W (5), FIFO data count
//
//   Ports (each wrapper)
//     clk     in   1   rising-edge clock
//     reset_n in   1   asynchronous active-low reset
//     en      in   1   load enable (only with DFF_R_LOAD_EN defined)
//     d       in   W   next value
//     q       out  W   registered value
//
//   Optional feature macro: DFF_R_LOAD_EN (adds en to every wrapper)
// ----------------------------------------------------------------------------
module dff3_r
    import dff_r_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
`ifdef DFF_R_LOAD_EN
    input  logic               en,
`endif
    input  logic [STATE_W-1:0] d,
    output logic [STATE_W-1:0] q
);

    dff_r #(
        .WIDTH     (STATE_W),
        .RESET_VAL (DFF_RST_VAL)
    ) u_dff (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d),
        .q       (q)
    );

endmodule : dff3_r

module dff4_r
    import dff_r_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
`ifdef DFF_R_LOAD_EN
    input  logic             en,
`endif
    input  logic [PTR_W-1:0] d,
    output logic [PTR_W-1:0] q
);

    dff_r #(
        .WIDTH     (PTR_W),
        .RESET_VAL (DFF_RST_VAL)
    ) u_dff (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d),
        .q       (q)
    );

endmodule : dff4_r

module dff5_r
    import dff_r_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
`ifdef DFF_R_LOAD_EN
    input  logic               en,
`endif
    input  logic [COUNT_W-1:0] d,
    output logic [COUNT_W-1:0] q
);

    dff_r #(
        .WIDTH     (COUNT_W),
        .RESET_VAL (DFF_RST_VAL)
    ) u_dff (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d),
        .q       (q)
    );

endmodule : dff5_r

// File: rtl/dff_r.sv
// ----------------------------------------------------------------------------
// dff_r
//   Width-generic D register with asynchronous active-low reset. Used for
//   FSM state, FIFO pointers and data counts across the datapath.
//
//   Parameters
//     WIDTH     : register width, legal 1..32 (default 3)
//     RESET_VAL : value forced onto q while reset_n is low, truncated to WIDTH
//
//   Ports
//     clk     in   1      rising-edge clock
//     reset_n in   1      asynchronous active-low reset
//     en      in   1      load enable (only with DFF_R_LOAD_EN defined)
//     d       in   WIDTH  next value
//     q       out  WIDTH  registered value
//
//   Optional feature macro: DFF_R_LOAD_EN
//     defined   : q loads d on a rising edge only when en is 1, else holds
//     undefined : no en port, q loads d on every rising edge
// ----------------------------------------------------------------------------
module dff_r
    import dff_r_pkg::*;
#(
    parameter int unsigned WIDTH     = STATE_W,
    parameter logic [31:0] RESET_VAL = DFF_RST_VAL
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef DFF_R_LOAD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset value narrowed to the register width; upper bits are dropped.
    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection: straight load, or load-or-hold when gated.
`ifdef DFF_R_LOAD_EN
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end
`else
    always_comb begin
        q_d = d;
    end
`endif

    // Reset acts on q without waiting for a clock edge and overrides any load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RST_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : dff_r

// File: tb/tb_dff_r.sv
// ----------------------------------------------------------------------------
// tb_dff_r
//   Directed bench for the dff_r core and its three fixed-width wrappers.
//   Inputs change on the falling clock edge; outputs are sampled 1 time unit
//   after the rising edge or after an asynchronous reset change.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dff_r;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [2:0] d3, q3;
    logic [3:0] d4, q4;
    logic [4:0] d5, q5;
    logic [7:0] dc, qc;

    int n_vec;
    int n_err;

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dff3_r u_d3 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d3),
        .q       (q3)
    );

    dff4_r u_d4 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d4),
        .q       (q4)
    );

    dff5_r u_d5 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (d5),
        .q       (q5)
    );

    // Core with a non-zero reset value wider than the register: 0x1A5 -> 0xA5.
    dff_r #(
        .WIDTH     (8),
        .RESET_VAL (32'h0000_01A5)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF_R_LOAD_EN
        .en      (en),
`endif
        .d       (dc),
        .q       (qc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        en      = 1'b1;
        d3      = 3'b111;
        d4      = 4'b1111;
        d5      = 5'b11111;
        dc      = 8'hFF;

        // Power-up: reset held for two edges with all-ones on d
        edge_sample();
        edge_sample();
        chk("pwr_q3", {29'd0, q3}, 32'd0);
        chk("pwr_q4", {28'd0, q4}, 32'd0);
        chk("pwr_q5", {27'd0, q5}, 32'd0);
        chk("pwr_core", {24'd0, qc}, 32'h0000_00A5);

        // Basic load after release, including full-range patterns
        @(negedge clk);
        reset_n = 1'b1;
        d3 = 3'b101;
        d4 = 4'b1111;
        d5 = 5'b10000;
        dc = 8'h3C;
        edge_sample();
        chk("load_q3", {29'd0, q3}, 32'd5);
        chk("load_q4", {28'd0, q4}, 32'd15);
        chk("load_q5", {27'd0, q5}, 32'd16);
        chk("load_core", {24'd0, qc}, 32'h0000_003C);

        // d changes between edges must not reach q until the next edge
        @(negedge clk);
        d3 = 3'b010;
        d5 = 5'b00001;
        dc = 8'hC3;
        #2;
        chk("hold_q3", {29'd0, q3}, 32'd5);
        chk("hold_q5", {27'd0, q5}, 32'd16);
        chk("hold_core", {24'd0, qc}, 32'h0000_003C);
        edge_sample();
        chk("next_q3", {29'd0, q3}, 32'd2);
        chk("next_q5", {27'd0, q5}, 32'd1);
        chk("next_core", {24'd0, qc}, 32'h0000_00C3);

        // Pointer sequence 0..15 then wrap to 0
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            d4 = 4'(i);
            edge_sample();
            chk($sformatf("seq_q4_%0d", i), {28'd0, q4}, 32'(i % 16));
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        d5 = 5'b01010;
        edge_sample();
        chk("pre_rst_q5", {27'd0, q5}, 32'd10);
        @(negedge clk);
        reset_n = 1'b0;
        d5 = 5'b11111;
        d3 = 3'b111;
        #1;
        chk("async_q5", {27'd0, q5}, 32'd0);
        chk("async_core", {24'd0, qc}, 32'h0000_00A5);
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            chk($sformatf("rst_hold_q5_%0d", i), {27'd0, q5}, 32'd0);
        end

        // Release coincident with a rising edge: that edge does not load
        @(posedge clk);
        reset_n <= 1'b1;
        #1;
        chk("rel_edge_q3", {29'd0, q3}, 32'd0);
        edge_sample();
        chk("rel_next_q3", {29'd0, q3}, 32'd7);

`ifdef DFF_R_LOAD_EN
        // Load-enable gating and reset priority over en
        @(negedge clk);
        en = 1'b1;
        d4 = 4'b0011;
        edge_sample();
        chk("en_pre_q4", {28'd0, q4}, 32'd3);
        @(negedge clk);
        en = 1'b0;
        d4 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            chk($sformatf("en0_q4_%0d", i), {28'd0, q4}, 32'd3);
        end
        @(negedge clk);
        en = 1'b1;
        edge_sample();
        chk("en1_q4", {28'd0, q4}, 32'd10);
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("en_rst_q4", {28'd0, q4}, 32'd0);
        reset_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dff_r

// File: doc/dff_r.md
# dff_r

Parameterized D flip-flop register with asynchronous active-low reset. It stores FSM state, FIFO head/tail pointers and data counts throughout the datapath. The block is a width-generic core plus three fixed-width wrappers, `dff3_r`, `dff4_r` and `dff5_r`, which existing parent modules instantiate by those names.

## Interface

Parameters:
- `WIDTH`, default 3: register width in bits, legal range 1..32.
- `RESET_VAL`, default 0: value loaded into `q` while reset is asserted; truncated to `WIDTH` bits.

Ports:
- `clk`  input  1: single clock; all loads occur on the rising edge.
- `reset_n`  input  1: reset. One clock; reset is asynchronous and active-low.
- `en`  input  1: load enable. Present only when `DFF_R_LOAD_EN` is defined.
- `d`  input  `WIDTH`: next value.
- `q`  output  `WIDTH`: registered value.

Wrapper ports:
- `dff3_r`, `dff4_r` and `dff5_r` expose only `clk`, `reset_n`, `d` and `q`.
- Their `WIDTH` is 3, 4 and 5 respectively; `RESET_VAL` is 0.

## Operation

- `reset_n` low:
  - `q` is forced to `RESET_VAL` immediately, with no clock edge required.
  - `q` holds that value for as long as `reset_n` stays low.
  - Clock edges and `d` are ignored.
- `reset_n` high, rising edge of `clk`:
  - `q` takes `d`.
  - With `DFF_R_LOAD_EN` defined, `q` takes `d` only when `en` is 1; otherwise it holds.
- Between clock edges, `q` is stable; changes on `d` have no effect until the next edge.
- No arithmetic and no saturation: `q` is exactly `d`.
  - Full-range values load unchanged: all-ones and the MSB-only pattern (5'b10000, the full-FIFO count).
- An X or Z on `d` at the edge propagates to `q`; it is not masked.
- `q` never presents an X after the first reset assertion unless `d` carried one.

## Timing

- Load latency: 1 clock. `d` sampled at edge N appears on `q` immediately after edge N.
- Reset assertion latency: 0 clocks, since reset acts asynchronously on `q`.
- Reset release: the first load occurs on the first rising edge after `reset_n` goes high.
  - Release coincident with a rising edge: that edge does not load; `q` stays at `RESET_VAL`.
- Reset mid-operation:
  - Asserting `reset_n` low between edges clears `q` at once.
  - A value captured before reset is lost.
- Reset value of `q`: `RESET_VAL`, which is 0 for all three wrappers.
- No combinational path from `d` to `q`.

## Configuration

- Macro: `DFF_R_LOAD_EN`.
- Defined:
  - The core and all wrappers gain the `en` input.
  - `en` = 0 holds `q` across clock edges.
  - Reset still overrides `en`.
- Undefined:
  - No `en` port exists.
  - The register loads `d` on every rising edge.
  - Wrapper port lists match the four-port form exactly.

## Structure

- Shared package holds the width constants:
  - `STATE_W` = 3 (FSM state).
  - `PTR_W` = 4 (16-entry head/tail pointers).
  - `COUNT_W` = 5 (data count 0..16).
- The package also holds the default reset value constant.
- The core `dff_r` is the single natural sub-module.
- `dff3_r`, `dff4_r` and `dff5_r` are thin wrappers instantiating `dff_r` with `STATE_W`, `PTR_W` and `COUNT_W`.

## Test plan

- Power-up: hold `reset_n` = 0 for 2 cycles with `d` = all-ones → `q` = 3'b000, 4'b0000 and 5'b00000 on the three wrappers, with no edge needed.
- Basic load:
  - Release reset; drive `d` = 3'b101, 4'b1111 and 5'b10000 before an edge → after that edge `q` equals these values.
  - Change `d` between edges → `q` unchanged until the next edge.
- Sequence: drive a 4-bit pointer `d` of 0, 1, …, 15 then 0 on consecutive edges → `q` follows one cycle behind, including the 15→0 wrap.
- Asynchronous reset mid-operation: with `q` = 5'b01010, pull `reset_n` low midway between edges → `q` = 0 immediately; `q` stays 0 across 3 edges while `d` = 5'b11111.
- Reset release on an edge: raise `reset_n` coincident with a rising edge while `d` = 3'b111 → `q` stays 0; `q` = 3'b111 after the next edge.
- With `DFF_R_LOAD_EN`:
  - `en` = 0 and `d` = 4'b1010 for 3 edges → `q` holds its prior value 4'b0011.
  - `en` = 1 → `q` = 4'b1010 after one edge.
